// File: rtl/force_bank_if.sv
// force_bank_if: command and commit bus between a pattern
// sequencer and force_bank.
interface force_bank_if #(
  parameter int CH_W  = 3,
  parameter int LEN_W = 16
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [CH_W-1:0]  CMD_CH;
  logic [1:0]       CMD_MODE;
  logic             CMD_VAL;
  logic [LEN_W-1:0] CMD_LEN;
  logic             CMD_IMM;
  logic             APPLY;
  logic             CMD_ERR;

  modport master (
    output CMD_VALID,
    output CMD_CH,
    output CMD_MODE,
    output CMD_VAL,
    output CMD_LEN,
    output CMD_IMM,
    output APPLY,
    input  CMD_READY,
    input  CMD_ERR
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_CH,
    input  CMD_MODE,
    input  CMD_VAL,
    input  CMD_LEN,
    input  CMD_IMM,
    input  APPLY,
    output CMD_READY,
    output CMD_ERR
  );
endinterface

// File: rtl/force_bank.sv
// force_bank: per-channel pad forcing with shadowed commands,
// committed together by APPLY or singly by CMD_IMM.
module force_bank #(
  parameter int    NCH   = 8,
  parameter int    CH_W  = 3,
  parameter int    LEN_W = 16,
  parameter int    DRIVE = 24,
  parameter string SLEW  = "FAST"
) (
  input  logic           CLK,
  input  logic           RST_N,
  force_bank_if.slave    cmd,
  inout  wire  [NCH-1:0] PAD,
  output logic [NCH-1:0] ACTIVE,
  output logic [NCH-1:0] PEND,
  output logic [NCH-1:0] DONE
);
  typedef enum logic [1:0] {
    S_REL,
    S_FRC,
    S_PUL
  } st_e;

  localparam logic [1:0] M_FRC = 2'd1;
  localparam logic [1:0] M_PUL = 2'd2;

  st_e              st_q  [NCH];
  st_e              st_d  [NCH];
  logic [LEN_W-1:0] cnt_q [NCH];
  logic [LEN_W-1:0] cnt_d [NCH];
  logic [1:0]       shm_q [NCH];
  logic [1:0]       shm_d [NCH];
  logic [LEN_W-1:0] shl_q [NCH];
  logic [LEN_W-1:0] shl_d [NCH];
  logic [1:0]       src_m [NCH];
  logic [LEN_W-1:0] src_l [NCH];

  logic [NCH-1:0] shv_q, shv_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] dat_q, dat_d;
  logic [NCH-1:0] tz_q, tz_d;
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] src_v;
  logic [NCH-1:0] wr;
  logic [NCH-1:0] commit;

  logic rdy_q;
  logic err_q, err_d;
  logic accept;
  logic ch_ok;

  always_comb begin
    accept = cmd.CMD_VALID && rdy_q;
    ch_ok  = int'(cmd.CMD_CH) < NCH;
    err_d  = accept && !ch_ok;
    for (int c = 0; c < NCH; c++) begin
      wr[c] = accept && ch_ok
              && (int'(cmd.CMD_CH) == c);
      // a write in the APPLY cycle joins that commit
      commit[c] = wr[c]
                ? (cmd.CMD_IMM || cmd.APPLY)
                : (cmd.APPLY && pend_q[c]);
      src_m[c] = wr[c] ? cmd.CMD_MODE : shm_q[c];
      src_v[c] = wr[c] ? cmd.CMD_VAL  : shv_q[c];
      src_l[c] = wr[c] ? cmd.CMD_LEN  : shl_q[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      st_d[c]   = st_q[c];
      cnt_d[c]  = cnt_q[c];
      dat_d[c]  = dat_q[c];
      tz_d[c]   = tz_q[c];
      done_d[c] = 1'b0;
      shm_d[c]  = shm_q[c];
      shv_d[c]  = shv_q[c];
      shl_d[c]  = shl_q[c];
      pend_d[c] = pend_q[c];

      if (wr[c]) begin
        shm_d[c]  = cmd.CMD_MODE;
        shv_d[c]  = cmd.CMD_VAL;
        shl_d[c]  = cmd.CMD_LEN;
        pend_d[c] = 1'b1;
      end

      if (commit[c]) begin
        pend_d[c] = 1'b0;
        unique case (1'b1)
          src_m[c] == M_FRC: begin
            st_d[c]  = S_FRC;
            dat_d[c] = src_v[c];
            tz_d[c]  = 1'b0;
            cnt_d[c] = '0;
          end
          src_m[c] == M_PUL && src_l[c] != '0: begin
            st_d[c]  = S_PUL;
            dat_d[c] = src_v[c];
            tz_d[c]  = 1'b0;
            cnt_d[c] = src_l[c];
          end
          default: begin
            st_d[c]  = S_REL;
            dat_d[c] = 1'b0;
            tz_d[c]  = 1'b1;
            cnt_d[c] = '0;
          end
        endcase
      end else if (st_q[c] == S_PUL) begin
        if (cnt_q[c] == LEN_W'(1)) begin
          st_d[c]   = S_REL;
          dat_d[c]  = 1'b0;
          tz_d[c]   = 1'b1;
          cnt_d[c]  = '0;
          done_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] - LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      pend_q <= '0;
      dat_q  <= '0;
      tz_q   <= '1;
      done_q <= '0;
      shv_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        st_q[c]  <= S_REL;
        cnt_q[c] <= '0;
        shm_q[c] <= '0;
        shl_q[c] <= '0;
      end
    end else begin
      rdy_q  <= 1'b1;
      err_q  <= err_d;
      pend_q <= pend_d;
      dat_q  <= dat_d;
      tz_q   <= tz_d;
      done_q <= done_d;
      shv_q  <= shv_d;
      for (int c = 0; c < NCH; c++) begin
        st_q[c]  <= st_d[c];
        cnt_q[c] <= cnt_d[c];
        shm_q[c] <= shm_d[c];
        shl_q[c] <= shl_d[c];
      end
    end
  end

  assign ACTIVE        = ~tz_q;
  assign PEND          = pend_q;
  assign DONE          = done_q;
  assign cmd.CMD_READY = rdy_q;
  assign cmd.CMD_ERR   = err_q;

  // output-only pad buffers; nothing is read back from the DUT
  for (genvar g = 0; g < NCH; g++) begin : g_pad
    if (DRIVE > 0 && SLEW != "") begin : g_drv
      assign PAD[g] = tz_q[g] ? 1'bz : dat_q[g];
    end else begin : g_off
      assign PAD[g] = 1'bz;
    end
  end
endmodule

// File: tb/tb_force_bank.sv
// tb_force_bank: directed vectors, expectations queued by the
// stimulus and checked by an independent monitor.
module tb_force_bank;
  localparam int NCH   = 6;
  localparam int CH_W  = 3;
  localparam int LEN_W = 16;

  typedef struct {
    logic              v;
    logic [CH_W-1:0]   ch;
    logic [1:0]        md;
    logic              vl;
    logic [LEN_W-1:0]  ln;
    logic              imm;
    logic              ap;
  } cmd_t;

  typedef struct {
    string          nm;
    logic           rdy;
    logic           err;
    logic [NCH-1:0] act;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] done;
    logic [NCH-1:0] padv;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  wire  [NCH-1:0] PAD;
  logic [NCH-1:0] ACTIVE;
  logic [NCH-1:0] PEND;
  logic [NCH-1:0] DONE;

  force_bank_if #(.CH_W(CH_W), .LEN_W(LEN_W)) bus ();

  force_bank #(
    .NCH(NCH), .CH_W(CH_W), .LEN_W(LEN_W),
    .DRIVE(24), .SLEW("FAST")
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .cmd(bus),
    .PAD(PAD),
    .ACTIVE(ACTIVE),
    .PEND(PEND),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  exp_t q[$];
  int   nvec  = 0;
  int   nmiss = 0;

  cmd_t NOP = '{v: 1'b0, ch: '0, md: '0, vl: 1'b0,
                ln: '0, imm: 1'b0, ap: 1'b0};
  cmd_t APL = '{v: 1'b0, ch: '0, md: '0, vl: 1'b0,
                ln: '0, imm: 1'b0, ap: 1'b1};

  function automatic cmd_t mk(input int ch, input int md,
                              input bit vl, input int ln,
                              input bit imm, input bit ap);
    cmd_t c;
    c.v   = 1'b1;
    c.ch  = CH_W'(ch);
    c.md  = 2'(md);
    c.vl  = vl;
    c.ln  = LEN_W'(ln);
    c.imm = imm;
    c.ap  = ap;
    return c;
  endfunction

  task automatic cy(input string nm, input logic rst,
                    input cmd_t c, input logic rdy,
                    input logic err, input logic [NCH-1:0] act,
                    input logic [NCH-1:0] pend,
                    input logic [NCH-1:0] done,
                    input logic [NCH-1:0] padv);
    exp_t e;
    @(negedge CLK);
    RST_N         = rst;
    bus.CMD_VALID = c.v;
    bus.CMD_CH    = c.ch;
    bus.CMD_MODE  = c.md;
    bus.CMD_VAL   = c.vl;
    bus.CMD_LEN   = c.ln;
    bus.CMD_IMM   = c.imm;
    bus.APPLY     = c.ap;
    e.nm   = nm;
    e.rdy  = rdy;
    e.err  = err;
    e.act  = act;
    e.pend = pend;
    e.done = done;
    e.padv = padv;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    bit   bad;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        e   = q.pop_front();
        bad = 1'b0;
        nvec++;
        if (bus.CMD_READY !== e.rdy) begin
          $display("FAIL %s ready: got %b want %b",
                   e.nm, bus.CMD_READY, e.rdy);
          bad = 1'b1;
        end
        if (bus.CMD_ERR !== e.err) begin
          $display("FAIL %s err: got %b want %b",
                   e.nm, bus.CMD_ERR, e.err);
          bad = 1'b1;
        end
        if (ACTIVE !== e.act) begin
          $display("FAIL %s active: got %h want %h",
                   e.nm, ACTIVE, e.act);
          bad = 1'b1;
        end
        if (PEND !== e.pend) begin
          $display("FAIL %s pend: got %h want %h",
                   e.nm, PEND, e.pend);
          bad = 1'b1;
        end
        if (DONE !== e.done) begin
          $display("FAIL %s done: got %h want %h",
                   e.nm, DONE, e.done);
          bad = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
          if (e.act[i] && PAD[i] !== e.padv[i]) begin
            $display("FAIL %s pad[%0d]: got %b want %b",
                     e.nm, i, PAD[i], e.padv[i]);
            bad = 1'b1;
          end
        end
        if (bad) nmiss++;
      end
    end
  end

  initial begin : stim
    bus.CMD_VALID = 1'b0;
    bus.CMD_CH    = '0;
    bus.CMD_MODE  = '0;
    bus.CMD_VAL   = 1'b0;
    bus.CMD_LEN   = '0;
    bus.CMD_IMM   = 1'b0;
    bus.APPLY     = 1'b0;

    // reset and release
    cy("rst_a", 0, NOP, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
    cy("rst_b", 0, NOP, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
    cy("rdy",   1, NOP, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00);

    // staged static forces, committed together
    cy("w2", 1, mk(2, 1, 1, 0, 0, 0),
       1, 0, 6'h00, 6'h04, 6'h00, 6'h00);
    cy("w5", 1, mk(5, 1, 0, 0, 0, 0),
       1, 0, 6'h00, 6'h24, 6'h00, 6'h00);
    cy("apply", 1, APL, 1, 0, 6'h24, 6'h00, 6'h00, 6'h04);
    cy("hold",  1, NOP, 1, 0, 6'h24, 6'h00, 6'h00, 6'h04);

    // immediate pulse len 4 on ch3
    cy("p4", 1, mk(3, 2, 1, 4, 1, 0),
       1, 0, 6'h2C, 6'h00, 6'h00, 6'h0C);
    for (int i = 0; i < 3; i++)
      cy("p4_run", 1, NOP, 1, 0, 6'h2C, 6'h00, 6'h00, 6'h0C);
    cy("p4_done", 1, NOP, 1, 0, 6'h24, 6'h00, 6'h08, 6'h04);
    cy("p4_post", 1, NOP, 1, 0, 6'h24, 6'h00, 6'h00, 6'h04);

    // pulse len 10 overridden at count 3
    cy("p10", 1, mk(3, 2, 1, 10, 1, 0),
       1, 0, 6'h2C, 6'h00, 6'h00, 6'h0C);
    for (int i = 0; i < 7; i++)
      cy("p10_run", 1, NOP, 1, 0, 6'h2C, 6'h00, 6'h00, 6'h0C);
    cy("ovr", 1, mk(3, 1, 0, 0, 1, 0),
       1, 0, 6'h2C, 6'h00, 6'h00, 6'h04);
    for (int i = 0; i < 12; i++)
      cy("ovr_hold", 1, NOP, 1, 0, 6'h2C, 6'h00, 6'h00, 6'h04);

    // invalid channel alongside APPLY
    cy("w1", 1, mk(1, 1, 1, 0, 0, 0),
       1, 0, 6'h2C, 6'h02, 6'h00, 6'h04);
    cy("bad7", 1, mk(7, 1, 1, 0, 0, 1),
       1, 1, 6'h2E, 6'h00, 6'h00, 6'h06);
    cy("bad7_post", 1, NOP, 1, 0, 6'h2E, 6'h00, 6'h00, 6'h06);
    cy("bad6", 1, mk(6, 2, 1, 5, 1, 0),
       1, 1, 6'h2E, 6'h00, 6'h00, 6'h06);
    cy("bad6_post", 1, NOP, 1, 0, 6'h2E, 6'h00, 6'h00, 6'h06);

    // len 0 pulse, reserved mode, overwrite, write+APPLY
    cy("len0", 1, mk(2, 2, 1, 0, 1, 0),
       1, 0, 6'h2A, 6'h00, 6'h00, 6'h02);
    cy("len0_post", 1, NOP, 1, 0, 6'h2A, 6'h00, 6'h00, 6'h02);
    cy("w5a", 1, mk(5, 1, 1, 0, 0, 0),
       1, 0, 6'h2A, 6'h20, 6'h00, 6'h02);
    cy("w5b", 1, mk(5, 3, 1, 0, 0, 0),
       1, 0, 6'h2A, 6'h20, 6'h00, 6'h02);
    cy("apply5", 1, APL, 1, 0, 6'h0A, 6'h00, 6'h00, 6'h02);
    cy("wr_apply", 1, mk(4, 1, 1, 0, 0, 1),
       1, 0, 6'h1A, 6'h00, 6'h00, 6'h12);

    // reset during pulse and static force
    cy("p0", 1, mk(0, 2, 1, 20, 1, 0),
       1, 0, 6'h1B, 6'h00, 6'h00, 6'h13);
    cy("w2p", 1, mk(2, 1, 1, 0, 0, 0),
       1, 0, 6'h1B, 6'h04, 6'h00, 6'h13);
    cy("mid_rst_a", 0, NOP, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
    cy("mid_rst_b", 0, NOP, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
    cy("rel", 1, NOP, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00);
    for (int i = 0; i < 22; i++)
      cy("quiet", 1, NOP, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00);

    // shortest pulse
    cy("p1", 1, mk(0, 2, 1, 1, 1, 0),
       1, 0, 6'h01, 6'h00, 6'h00, 6'h01);
    cy("p1_done", 1, NOP, 1, 0, 6'h00, 6'h00, 6'h01, 6'h00);
    cy("p1_post", 1, NOP, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(posedge CLK);
    #3;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", q.size());
      nmiss++;
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmiss);
    $finish;
  end
endmodule
